// File: rtl/val2_serial_shifter.sv
// Operand-2 generator for the execute-stage ALU: builds Val2 from the shifter operand and Rm.
// Latency: 1 cycle for amount 0 or mem_en, N+1 cycles for a shift or rotate of N positions.
// Backpressure: combinational stall_req freezes upstream while a shift is pending or running.
module val2_serial_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imm,
  input  logic             mem_en,
  input  logic [11:0]      shift_operand,
  input  logic [WIDTH-1:0] Val_Rm,
  input  logic             flush,
  output logic [WIDTH-1:0] Val2,
  output logic             shift_carry,
  output logic             valid,
  output logic             busy,
  output logic             stall_req
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // FSM state
  state_t state_q, state_d;

  // Shift engine: working register, remaining positions, latched shift type
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [4:0]       cnt_q,  cnt_d;
  logic [1:0]       type_q, type_d;

  // Architecturally visible results
  logic [WIDTH-1:0] val2_q,  val2_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;

  // Operand selection results
  logic [WIDTH-1:0] sel_value;
  logic [4:0]       sel_amt;
  logic [1:0]       sel_type;
  logic             need_shift;

  // One-position step of the shift engine
  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  logic             idle;
  logic             last_step;

  assign idle       = (state_q == ST_IDLE);
  assign need_shift = (sel_amt != 5'd0);
  // The counter never starts at 0 in SHIFT, but exiting on <=1 keeps a
  // corrupted counter from wrapping through 31 more positions.
  assign last_step  = (cnt_q <= 5'd1);

  // Pick value, amount and type from the instruction encoding (mem_en beats imm)
  always_comb begin
    sel_value = Val_Rm;
    sel_amt   = 5'd0;
    sel_type  = SH_LSL;
    if (mem_en) begin
      sel_value = {{(WIDTH-12){1'b0}}, shift_operand};
    end else if (imm) begin
      sel_value = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
      sel_amt   = {shift_operand[11:8], 1'b0};
      sel_type  = SH_ROR;
    end else begin
      sel_type = shift_operand[6:5];
      // Register-specified shifts are not supported: pass Rm through unshifted.
      if (!shift_operand[4]) begin
        sel_amt = shift_operand[11:7];
      end
    end
  end

  // Single-position shift/rotate of the working register and the bit it drops
  always_comb begin
    step_val   = sreg_q;
    step_carry = 1'b0;
    case (type_q)
      SH_LSL: begin
        step_val   = {sreg_q[WIDTH-2:0], 1'b0};
        step_carry = sreg_q[WIDTH-1];
      end
      SH_LSR: begin
        step_val   = {1'b0, sreg_q[WIDTH-1:1]};
        step_carry = sreg_q[0];
      end
      SH_ASR: begin
        step_val   = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
        step_carry = sreg_q[0];
      end
      default: begin
        step_val   = {sreg_q[0], sreg_q[WIDTH-1:1]};
        step_carry = sreg_q[0];
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: flush always lands in IDLE, shifts leave SHIFT on the last step
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && need_shift) begin
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last_step) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: busy in SHIFT, stall as soon as a shifting start is presented
  always_comb begin
    busy      = (state_q == ST_SHIFT);
    stall_req = busy | (start & idle & need_shift);
  end

  // Datapath next state: load on start, step while shifting, publish only final results
  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    val2_d  = val2_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (flush) begin
      // Abandon the shift; the previously published Val2/carry stay put.
      cnt_d = 5'd0;
    end else if (idle) begin
      if (start) begin
        if (need_shift) begin
          sreg_d = sel_value;
          cnt_d  = sel_amt;
          type_d = sel_type;
        end else begin
          val2_d  = sel_value;
          carry_d = 1'b0;
          valid_d = 1'b1;
        end
      end
    end else begin
      sreg_d = step_val;
      cnt_d  = cnt_q - 5'd1;
      if (last_step) begin
        val2_d  = step_val;
        carry_d = step_carry;
        valid_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q  <= '0;
      cnt_q   <= 5'd0;
      type_q  <= SH_LSL;
      val2_q  <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      val2_q  <= val2_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign Val2        = val2_q;
  assign shift_carry = carry_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_val2_serial_shifter.sv
// Directed bench for val2_serial_shifter with hand-computed expected operands.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Every DUT wait is bounded so a hung shift still reaches the summary line.
module tb_val2_serial_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imm;
  logic        mem_en;
  logic [11:0] shift_operand;
  logic [31:0] Val_Rm;
  logic        flush;
  logic [31:0] Val2;
  logic        shift_carry;
  logic        valid;
  logic        busy;
  logic        stall_req;

  int n_tests;
  int n_fail;

  val2_serial_shifter #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .imm          (imm),
    .mem_en       (mem_en),
    .shift_operand(shift_operand),
    .Val_Rm       (Val_Rm),
    .flush        (flush),
    .Val2         (Val2),
    .shift_carry  (shift_carry),
    .valid        (valid),
    .busy         (busy),
    .stall_req    (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation in the current cycle, follow it to its valid cycle and
  // check the busy length, stall/valid behaviour during the shift and the result.
  // Returns in the valid cycle with start deasserted, so a back-to-back start can follow.
  task automatic run_op(input string tag, input logic [11:0] so, input logic i_bit,
                        input logic m_bit, input logic [31:0] rm, input int n,
                        input logic [31:0] exp_val, input logic exp_c);
    int busy_cycles;
    int bad;
    logic [31:0] prev_val2;
    prev_val2     = Val2;
    shift_operand = so;
    imm           = i_bit;
    mem_en        = m_bit;
    Val_Rm        = rm;
    start         = 1'b1;
    #1;
    check({tag, ".stall_start"}, {31'd0, stall_req}, {31'd0, (n != 0)});
    tick();
    start  = 1'b0;
    imm    = 1'b0;
    mem_en = 1'b0;
    busy_cycles = 0;
    bad         = 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      if (stall_req !== 1'b1 || valid !== 1'b0 || Val2 !== prev_val2) bad++;
      busy_cycles++;
      tick();
    end
    check({tag, ".busy_cycles"}, busy_cycles, n);
    check({tag, ".during_shift"}, bad, 0);
    check({tag, ".valid"}, {31'd0, valid}, 32'd1);
    check({tag, ".val2"}, Val2, exp_val);
    check({tag, ".carry"}, {31'd0, shift_carry}, {31'd0, exp_c});
    check({tag, ".stall_done"}, {31'd0, stall_req}, 32'd0);
  endtask

  initial begin
    int vcount;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    start         = 1'b0;
    imm           = 1'b0;
    mem_en        = 1'b0;
    shift_operand = 12'h000;
    Val_Rm        = 32'h0;
    flush         = 1'b0;

    tick();
    tick();
    check("rst.val2",  Val2, 32'h0);
    check("rst.carry", {31'd0, shift_carry}, 32'd0);
    check("rst.valid", {31'd0, valid}, 32'd0);
    check("rst.busy",  {31'd0, busy}, 32'd0);
    check("rst.stall", {31'd0, stall_req}, 32'd0);
    rst = 1'b0;
    tick();

    // Load/store offset: zero-extended, single cycle, no stall
    run_op("mem", 12'hABC, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 32'h0000_0ABC, 1'b0);
    tick();
    check("mem.pulse_end", {31'd0, valid}, 32'd0);

    // Immediate 0xFF rotated right by 8
    run_op("imm_ror8", 12'h4FF, 1'b1, 1'b0, 32'h0, 8, 32'hFF00_0000, 1'b1);
    tick();

    // Register ASR #4: sign bit replicated, carry is original bit 3
    run_op("asr4", 12'h240, 1'b0, 1'b0, 32'h8000_0010, 4, 32'hF800_0001, 1'b0);
    tick();

    // Register LSR #1: shortest shift, carry is original bit 0
    run_op("lsr1", 12'h0A0, 1'b0, 1'b0, 32'h0000_0003, 1, 32'h0000_0001, 1'b1);
    tick();

    // Register-specified shift (bit 4 set) degrades to a plain Rm pass-through
    run_op("regshift", 12'h0F0, 1'b0, 1'b0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0);
    tick();

    // LSL #31, then an immediate start in the same cycle that valid is high
    run_op("lsl31", 12'hF80, 1'b0, 1'b0, 32'h0000_0003, 31, 32'h8000_0000, 1'b1);
    run_op("b2b", 12'h012, 1'b1, 1'b0, 32'h0, 0, 32'h0000_0012, 1'b0);
    tick();

    // ROR #8 flushed in busy cycle 3: no result, Val2 keeps the previous operand
    shift_operand = 12'h460;
    Val_Rm        = 32'h1234_5678;
    start         = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("flush.busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy",  {31'd0, busy}, 32'd0);
    check("flush.stall", {31'd0, stall_req}, 32'd0);
    check("flush.val2",  Val2, 32'h0000_0012);
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (valid === 1'b1) vcount++;
      tick();
    end
    check("flush.no_valid", vcount, 0);

    // flush and start together in IDLE: nothing starts
    shift_operand = 12'h240;
    Val_Rm        = 32'h8000_0010;
    start         = 1'b1;
    flush         = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("flush_start.busy",  {31'd0, busy}, 32'd0);
    check("flush_start.valid", {31'd0, valid}, 32'd0);
    check("flush_start.val2",  Val2, 32'h0000_0012);

    // Reset in the middle of a shift, then a normal single-cycle operation
    shift_operand = 12'h460;
    Val_Rm        = 32'h1234_5678;
    start         = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.val2",  Val2, 32'h0);
    check("midrst.carry", {31'd0, shift_carry}, 32'd0);
    check("midrst.valid", {31'd0, valid}, 32'd0);
    check("midrst.busy",  {31'd0, busy}, 32'd0);
    check("midrst.stall", {31'd0, stall_req}, 32'd0);
    run_op("after_rst", 12'h123, 1'b0, 1'b1, 32'h0, 0, 32'h0000_0123, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/val2_serial_shifter.md
# val2_serial_shifter

Sequential operand-2 generator that sits directly upstream of the execute-stage ALU. It turns the instruction's 12-bit shifter operand plus the Rm register value into the 32-bit Val2 operand the ALU consumes. Shifts and rotates are performed one bit position per clock, trading latency for area. While a shift is in progress the block raises a stall request so the pipeline freezes.

## Interface

Parameters:
- `WIDTH`, default 32: datapath width of Val_Rm and Val2. Only 32 is supported.

Ports:
- `clk`, input, 1: system clock. Single clock domain; all state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `start`, input, 1: request to generate Val2 for the instruction currently presented. Sampled only in IDLE.
- `imm`, input, 1: I-bit. 1 selects the rotated 8-bit immediate.
- `mem_en`, input, 1: load/store instruction. 1 selects the 12-bit unsigned offset.
- `shift_operand`, input, 12: instruction bits [11:0].
- `Val_Rm`, input, 32: Rm register value, already forwarded.
- `flush`, input, 1: abort any operation in progress (branch taken).
- `Val2`, output, 32: generated operand. Held stable between completions.
- `shift_carry`, output, 1: last bit shifted or rotated out. 0 when no shift occurred.
- `valid`, output, 1: one-cycle pulse when Val2 and shift_carry are updated.
- `busy`, output, 1: high while in SHIFT state.
- `stall_req`, output, 1: combinational. Equals `busy | (start & idle & need_shift)`.

## Operation

Operand selection, evaluated at the start edge in priority order:
- `mem_en=1`: result = {20'b0, shift_operand[11:0]}. Amount 0.
- `imm=1`: value = {24'b0, shift_operand[7:0]}. Type ROR. Amount = 2 × shift_operand[11:8], range 0..30.
- Otherwise: value = Val_Rm. Amount = shift_operand[11:7]. Type from shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - If shift_operand[4]=1 (register-specified shift, unsupported), force amount to 0, so result = Val_Rm.
- Amount 0 means "no shift" for every type; there is no LSR/ASR #32 or RRX encoding.
- `need_shift` is true when the selected amount is nonzero.

State machine, two states:
- IDLE, with `start=1`:
  - If amount is 0: load Val2 with the selected value, clear shift_carry, pulse valid. Stay in IDLE.
  - Otherwise: load internal shift register with value, counter with amount, and latch the type. Go to SHIFT.
- IDLE, with `start=0`: hold all outputs.
- SHIFT, each clock: shift one position and decrement the counter.
  - LSL: carry = bit 31, shift in 0.
  - LSR: carry = bit 0, shift in 0.
  - ASR: carry = bit 0, shift in bit 31.
  - ROR: carry = bit 0, bit 0 moves to bit 31.
- SHIFT exit: on the edge where the counter goes 1 to 0, write the final register value to Val2 and the last carry to shift_carry, pulse valid, and return to IDLE.
- Val2 never shows intermediate shift values.

Boundary conditions:
- `start` while busy is ignored. Upstream is frozen by stall_req, so this does not occur legally.
- `flush`, in any state, returns to IDLE on that edge with no valid pulse. Val2 and shift_carry keep their previous values.
- `flush` and `start` in the same IDLE cycle: flush wins and nothing starts.
- `rst` overrides flush and start.
- The counter is 5 bits. The maximum amount is 31 (register form) or 30 (immediate form), so no wrap-around occurs.

## Timing

- Reset values: Val2=0, shift_carry=0, valid=0, busy=0. State IDLE, counter 0. stall_req=0 because busy=0 and no start is accepted during reset.
- Amount 0 or mem_en: valid is high in the cycle after the start edge. Latency 1 cycle; stall_req stays 0.
- Amount N > 0: busy is high for N cycles after the start edge. valid is high in cycle N+1. Total latency N+1 cycles.
- stall_req is high in the start cycle and in every busy cycle. It is low in the cycle where valid is high, so the pipeline advances together with the new Val2.
- Back-to-back operations: a new start is accepted in the same cycle that valid is high.
- Throughput: one operation per N+1 cycles.

## Test plan

- Reset, then `mem_en=1`, shift_operand=12'hABC, start: cycle 1 gives valid=1, Val2=32'h00000ABC, shift_carry=0, stall_req never high.
- `imm=1`, shift_operand=12'h4FF (rotate 8), start: stall_req high for cycles 0..8, busy for 8 cycles. Cycle 9 gives Val2=32'hFF000000, shift_carry=1, valid=1.
- Register ASR #4 (shift_operand[11:7]=4, [6:5]=10, [4]=0), Val_Rm=32'h80000010: cycle 5 gives Val2=32'hF8000001, shift_carry=0.
- Register LSL #31, Val_Rm=32'h00000003: cycle 32 gives Val2=32'h80000000, shift_carry=1. Then an immediate start in that same cycle with shift_operand=12'h012 gives Val2=32'h00000012 in cycle 33.
- Register ROR #8, Val_Rm=32'h12345678, with flush asserted in busy cycle 3: back to IDLE, no valid, Val2 unchanged from the prior result, stall_req low the next cycle.
- Assert `rst` mid-SHIFT: on the next edge all outputs return to their reset values, and a subsequent start with amount 0 completes normally.
